native_aip_buf: RTL and testbench

NATIVE_AIP_BUF -- requirements
Module: native_aip_buf

---
 rtl/native_aip_buf_pkg.sv | 27 ++
 rtl/aip_sync_fifo.sv | 54 +++++
 rtl/native_aip_buf.sv | 244 ++++++++++++++++++++++++
 tb/tb_native_aip_buf.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/native_aip_buf_pkg.sv
// Shared definitions for the native AIP buffer: register offsets,
// controller FSM states and STATUS field positions.
package native_aip_buf_pkg;

  localparam logic [7:0] REG_RDATA  = 8'h00;
  localparam logic [7:0] REG_WDATA  = 8'h04;
  localparam logic [7:0] REG_CONFIG = 8'h08;
  localparam logic [7:0] REG_CTRL   = 8'h0C;
  localparam logic [7:0] REG_RDCNT  = 8'h10;
  localparam logic [7:0] REG_STATUS = 8'h14;
  localparam logic [7:0] REG_IRQ    = 8'h18;

  // STATUS = {wlevel, rlevel, busy, wovf, runf}; level fields are
  // $clog2(depth)+1 bits wide, rlevel starts at STAT_RLVL and wlevel follows.
  localparam int STAT_RUNF = 0;
  localparam int STAT_WOVF = 1;
  localparam int STAT_BUSY = 2;
  localparam int STAT_RLVL = 3;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_PUSH      = 2'd1,
    ST_FETCH_REQ = 2'd2,
    ST_FETCH_CAP = 2'd3
  } state_e;

endpackage

// File: rtl/aip_sync_fifo.sv
// Single-clock show-ahead FIFO. Pointers carry one extra bit so that
// full and empty are distinguishable; a push into a full FIFO is accepted
// only when a pop happens in the same cycle.
module aip_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_wdata,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_rdata,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_level
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wptr_q, wptr_d, rptr_q, rptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign o_empty = (wptr_q == rptr_q);
  assign o_full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign o_level = wptr_q - rptr_q;
  assign o_rdata = mem_q[rptr_q[AW-1:0]];

  // Qualify push/pop against occupancy and advance the pointers.
  always_comb begin
    do_pop  = i_pop & ~o_empty;
    do_push = i_push & (~o_full | do_pop);
    wptr_d  = wptr_q + {{AW{1'b0}}, do_push};
    rptr_d  = rptr_q + {{AW{1'b0}}, do_pop};
  end

  // Pointer registers; reset empties the FIFO.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage array; contents are don't-care while empty so it is not reset.
  always_ff @(posedge i_clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/native_aip_buf.sv
// Native CPU-bus to AIP core bridge with a write FIFO drained into the core
// and a read FIFO filled from the core under an RDCNT word budget.
// Optional feature macro: NATIVE_AIP_BUF_IRQ_EN (registered, maskable,
// W1C interrupt); without it the core interrupt passes straight through.
module native_aip_buf
  import native_aip_buf_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int CONFIG_W   = 5
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_cpu_mem_valid,
  input  logic [31:0]         i_cpu_mem_addr,
  input  logic [DATA_W-1:0]   i_cpu_mem_wdata,
  input  logic                i_cpu_mem_wen,
  output logic [DATA_W-1:0]   o_cpu_mem_rdata,
  output logic                o_cpu_mem_ready,
  input  logic                i_aip_sel,
  input  logic                i_aip_enable,
  input  logic [DATA_W-1:0]   i_aip_dataOut,
  output logic [DATA_W-1:0]   o_aip_dataIn,
  output logic [CONFIG_W-1:0] o_aip_config,
  output logic                o_aip_read,
  output logic                o_aip_write,
  output logic                o_aip_start,
  input  logic                i_aip_int,
  output logic                o_core_int
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  state_e              state_q, state_d;
  logic                ready_q, ready_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [CONFIG_W-1:0] config_q, config_d;
  logic [DATA_W-1:0]   rdcnt_q, rdcnt_d;
  logic                rdcnt_ovr_q, rdcnt_ovr_d;
  logic                wovf_q, wovf_d, runf_q, runf_d;
  logic                start_q, start_d;

  logic                access;
  logic [7:0]          reg_addr;
  logic [DATA_W-1:0]   status_word, irq_word;
  logic                pop_req, aip_write, aip_read;

  logic                wf_push, wf_pop, wf_full, wf_empty;
  logic [DATA_W-1:0]   wf_rdata;
  logic [LW-1:0]       wf_level;
  logic                rf_push, rf_pop, rf_full, rf_empty;
  logic [DATA_W-1:0]   rf_rdata;
  logic [LW-1:0]       rf_level;
  logic                unused_addr;

  // A held request is not re-accepted while its ready pulse is out.
  assign access      = i_cpu_mem_valid & i_aip_sel & i_aip_enable & ~ready_q;
  assign reg_addr    = i_cpu_mem_addr[7:0];
  assign unused_addr = ^i_cpu_mem_addr[31:8];
  assign wf_pop      = pop_req;

  aip_sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_wfifo (
    .i_clk(i_clk), .i_rst(i_rst), .i_push(wf_push), .i_wdata(i_cpu_mem_wdata),
    .i_pop(wf_pop), .o_rdata(wf_rdata), .o_full(wf_full), .o_empty(wf_empty),
    .o_level(wf_level)
  );

  aip_sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_rfifo (
    .i_clk(i_clk), .i_rst(i_rst), .i_push(rf_push), .i_wdata(i_aip_dataOut),
    .i_pop(rf_pop), .o_rdata(rf_rdata), .o_full(rf_full), .o_empty(rf_empty),
    .o_level(rf_level)
  );

  // Pack the STATUS word from live FIFO levels, FSM state and sticky flags.
  always_comb begin
    status_word                     = '0;
    status_word[STAT_RUNF]          = runf_q;
    status_word[STAT_WOVF]          = wovf_q;
    status_word[STAT_BUSY]          = (state_q != ST_IDLE);
    status_word[STAT_RLVL +: LW]    = rf_level;
    status_word[STAT_RLVL+LW +: LW] = wf_level;
  end

  // Controller FSM: drain the write FIFO first, otherwise fetch RDCNT words.
  always_comb begin
    state_d   = state_q;
    pop_req   = 1'b0;
    rf_push   = 1'b0;
    aip_write = 1'b0;
    aip_read  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!wf_empty) state_d = ST_PUSH;
        else if ((rdcnt_q != '0) && !rf_full) state_d = ST_FETCH_REQ;
      end
      ST_PUSH: begin
        pop_req   = ~wf_empty;
        aip_write = ~wf_empty;
        if (wf_empty || ((wf_level == LW'(1)) && !wf_push)) state_d = ST_IDLE;
      end
      ST_FETCH_REQ: begin
        aip_read = 1'b1;
        state_d  = ST_FETCH_CAP;
      end
      ST_FETCH_CAP: begin
        rf_push = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // CPU register file: decode accesses, FIFO push/pop, sticky flags, RDCNT.
  always_comb begin
    ready_d     = access;
    rdata_d     = rdata_q;
    config_d    = config_q;
    rdcnt_d     = rdcnt_q;
    rdcnt_ovr_d = rdcnt_ovr_q;
    wovf_d      = wovf_q;
    runf_d      = runf_q;
    start_d     = 1'b0;
    wf_push     = 1'b0;
    rf_pop      = 1'b0;
    // A CPU write of RDCNT during FETCH_REQ replaces the pending decrement.
    if (state_q == ST_FETCH_CAP) begin
      if (!rdcnt_ovr_q) rdcnt_d = rdcnt_q - DATA_W'(1);
      rdcnt_ovr_d = 1'b0;
    end
    if (access) begin
      rdata_d = '0;
      if (i_cpu_mem_wen) begin
        case (reg_addr)
          REG_WDATA: begin
            if (wf_full && !wf_pop) wovf_d = 1'b1;
            else wf_push = 1'b1;
          end
          REG_CONFIG: config_d = i_cpu_mem_wdata[CONFIG_W-1:0];
          REG_CTRL:   start_d  = i_cpu_mem_wdata[0];
          REG_RDCNT: begin
            rdcnt_d = i_cpu_mem_wdata;
            if (state_q == ST_FETCH_REQ) rdcnt_ovr_d = 1'b1;
          end
          default: ;
        endcase
      end else begin
        case (reg_addr)
          REG_RDATA: begin
            if (!rf_empty) begin
              rf_pop  = 1'b1;
              rdata_d = rf_rdata;
            end else begin
              runf_d = 1'b1;
            end
          end
          REG_CONFIG: rdata_d = DATA_W'(config_q);
          REG_RDCNT:  rdata_d = rdcnt_q;
          REG_STATUS: begin
            rdata_d = status_word;
            wovf_d  = 1'b0;
            runf_d  = 1'b0;
          end
          REG_IRQ:    rdata_d = irq_word;
          default: ;
        endcase
      end
    end
  end

  // State and register updates; reset aborts any transfer in flight.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      ready_q     <= 1'b0;
      rdata_q     <= '0;
      config_q    <= '0;
      rdcnt_q     <= '0;
      rdcnt_ovr_q <= 1'b0;
      wovf_q      <= 1'b0;
      runf_q      <= 1'b0;
      start_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      rdata_q     <= rdata_d;
      config_q    <= config_d;
      rdcnt_q     <= rdcnt_d;
      rdcnt_ovr_q <= rdcnt_ovr_d;
      wovf_q      <= wovf_d;
      runf_q      <= runf_d;
      start_q     <= start_d;
    end
  end

`ifdef NATIVE_AIP_BUF_IRQ_EN
  logic irq_wr;
  logic pend_q, pend_d, irq_en_q, irq_en_d, int_prev_q, int_prev_d, core_int_q, core_int_d;

  assign irq_wr = access & i_cpu_mem_wen & (reg_addr == REG_IRQ);

  // Pending latches on a core interrupt rising edge (wins over W1C).
  always_comb begin
    pend_d     = pend_q;
    irq_en_d   = irq_en_q;
    int_prev_d = i_aip_int;
    if (irq_wr) begin
      if (i_cpu_mem_wdata[0]) pend_d = 1'b0;
      irq_en_d = i_cpu_mem_wdata[1];
    end
    if (i_aip_int && !int_prev_q) pend_d = 1'b1;
    core_int_d = pend_d & irq_en_d;
  end

  // Interrupt state and registered CPU interrupt.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pend_q     <= 1'b0;
      irq_en_q   <= 1'b0;
      int_prev_q <= 1'b0;
      core_int_q <= 1'b0;
    end else begin
      pend_q     <= pend_d;
      irq_en_q   <= irq_en_d;
      int_prev_q <= int_prev_d;
      core_int_q <= core_int_d;
    end
  end

  assign irq_word   = DATA_W'({irq_en_q, pend_q});
  assign o_core_int = core_int_q;
`else
  assign irq_word   = '0;
  assign o_core_int = i_aip_int;
`endif

  assign o_cpu_mem_ready = ready_q;
  assign o_cpu_mem_rdata = rdata_q;
  assign o_aip_config    = config_q;
  assign o_aip_start     = start_q;
  assign o_aip_write     = aip_write;
  assign o_aip_read      = aip_read;
  assign o_aip_dataIn    = aip_write ? wf_rdata : '0;

endmodule

// File: tb/tb_native_aip_buf.sv
// Directed self-checking bench for native_aip_buf (default parameters).
module tb_native_aip_buf;

  logic        i_clk;
  logic        i_rst;
  logic        i_cpu_mem_valid;
  logic [31:0] i_cpu_mem_addr;
  logic [31:0] i_cpu_mem_wdata;
  logic        i_cpu_mem_wen;
  logic [31:0] o_cpu_mem_rdata;
  logic        o_cpu_mem_ready;
  logic        i_aip_sel;
  logic        i_aip_enable;
  logic [31:0] i_aip_dataOut;
  logic [31:0] o_aip_dataIn;
  logic [4:0]  o_aip_config;
  logic        o_aip_read;
  logic        o_aip_write;
  logic        o_aip_start;
  logic        i_aip_int;
  logic        o_core_int;

  int          n_cmp;
  int          n_err;
  logic [31:0] wr_log[$];
  logic [31:0] aip_src[8];
  int          src_idx;
  int          rd_pulses;
  int          start_cnt;

  native_aip_buf dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_cpu_mem_valid(i_cpu_mem_valid), .i_cpu_mem_addr(i_cpu_mem_addr),
    .i_cpu_mem_wdata(i_cpu_mem_wdata), .i_cpu_mem_wen(i_cpu_mem_wen),
    .o_cpu_mem_rdata(o_cpu_mem_rdata), .o_cpu_mem_ready(o_cpu_mem_ready),
    .i_aip_sel(i_aip_sel), .i_aip_enable(i_aip_enable),
    .i_aip_dataOut(i_aip_dataOut), .o_aip_dataIn(o_aip_dataIn),
    .o_aip_config(o_aip_config), .o_aip_read(o_aip_read),
    .o_aip_write(o_aip_write), .o_aip_start(o_aip_start),
    .i_aip_int(i_aip_int), .o_core_int(o_core_int)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // AIP core model: logs pushed words, answers read strobes, counts starts.
  initial begin
    i_aip_dataOut = '0;
    forever begin
      @(negedge i_clk);
      if (o_aip_write) wr_log.push_back(o_aip_dataIn);
      if (o_aip_start) start_cnt++;
      if (o_aip_read) begin
        rd_pulses++;
        i_aip_dataOut = (src_idx < 8) ? aip_src[src_idx] : 32'hDEAD_BEEF;
        src_idx++;
      end
    end
  end

  task automatic cpu(input logic wen, input logic [7:0] addr, input logic [31:0] wd,
                     output logic [31:0] rd);
    bit got;
    got = 1'b0;
    rd  = '0;
    i_cpu_mem_valid = 1'b1;
    i_cpu_mem_wen   = wen;
    i_cpu_mem_addr  = {24'h0, addr};
    i_cpu_mem_wdata = wd;
    for (int i = 0; i < 6 && !got; i++) begin
      @(negedge i_clk);
      if (o_cpu_mem_ready) begin
        got = 1'b1;
        rd  = o_cpu_mem_rdata;
      end
    end
    i_cpu_mem_valid = 1'b0;
    i_cpu_mem_wen   = 1'b0;
    if (!got) begin
      n_cmp++; n_err++;
      $display("FAIL cpu_ready_timeout addr=%h got no ready, required ready within 6 cycles", addr);
    end
  endtask

  task automatic wr(input logic [7:0] addr, input logic [31:0] wd);
    logic [31:0] dummy;
    cpu(1'b1, addr, wd, dummy);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  task automatic test_reset();
    logic [31:0] r;
    n_cmp++;
    if ({o_cpu_mem_ready, o_aip_read, o_aip_write, o_aip_start, o_core_int} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_ctrl_outputs got %b required 00000",
               {o_cpu_mem_ready, o_aip_read, o_aip_write, o_aip_start, o_core_int});
    end
    n_cmp++;
    if ({o_cpu_mem_rdata, o_aip_dataIn, o_aip_config} !== 69'h0) begin
      n_err++;
      $display("FAIL reset_data_outputs got rdata=%h dataIn=%h config=%h required 0",
               o_cpu_mem_rdata, o_aip_dataIn, o_aip_config);
    end
    cpu(1'b0, 8'h14, 32'h0, r);
    n_cmp++;
    if (r !== 32'h0) begin n_err++; $display("FAIL reset_status got %h required 00000000", r); end
    cpu(1'b0, 8'h10, 32'h0, r);
    n_cmp++;
    if (r !== 32'h0) begin n_err++; $display("FAIL reset_rdcnt got %h required 00000000", r); end
  endtask

  task automatic test_config();
    logic [31:0] r;
    wr(8'h08, 32'h0000_003F);
    cpu(1'b0, 8'h08, 32'h0, r);
    n_cmp++;
    if (r !== 32'h1F) begin n_err++; $display("FAIL config_readback got %h required 0000001f", r); end
    n_cmp++;
    if (o_aip_config !== 5'h1F) begin n_err++; $display("FAIL config_port got %h required 1f", o_aip_config); end
    wr(8'h20, 32'h1234_5678);
    cpu(1'b0, 8'h20, 32'h0, r);
    n_cmp++;
    if (r !== 32'h0) begin n_err++; $display("FAIL unmapped_read got %h required 00000000", r); end
  endtask

  task automatic test_push();
    logic [31:0] r;
    logic [31:0] exp_w[3];
    exp_w[0] = 32'hA5A5_0001; exp_w[1] = 32'hA5A5_0002; exp_w[2] = 32'hA5A5_0003;
    wr_log.delete();
    for (int i = 0; i < 3; i++) wr(8'h04, exp_w[i]);
    idle(8);
    n_cmp++;
    if (wr_log.size() != 3) begin
      n_err++; $display("FAIL push_count got %0d required 3", wr_log.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (wr_log[i] !== exp_w[i]) begin
          n_err++; $display("FAIL push_data[%0d] got %h required %h", i, wr_log[i], exp_w[i]);
        end
      end
    end
    cpu(1'b0, 8'h14, 32'h0, r);
    n_cmp++;
    if (r !== 32'h0) begin n_err++; $display("FAIL push_status got %h required 00000000", r); end
  endtask

  task automatic test_fetch();
    logic [31:0] r;
    for (int i = 0; i < 8; i++) aip_src[i] = 32'h10 + i;
    src_idx = 0; rd_pulses = 0;
    wr(8'h10, 32'd4);
    idle(20);
    n_cmp++;
    if (rd_pulses != 4) begin n_err++; $display("FAIL fetch_read_pulses got %0d required 4", rd_pulses); end
    cpu(1'b0, 8'h14, 32'h0, r);
    n_cmp++;
    if (r !== 32'h20) begin n_err++; $display("FAIL fetch_status got %h required 00000020", r); end
    for (int i = 0; i < 4; i++) begin
      cpu(1'b0, 8'h00, 32'h0, r);
      n_cmp++;
      if (r !== 32'h10 + i) begin
        n_err++; $display("FAIL fetch_rdata[%0d] got %h required %h", i, r, 32'h10 + i);
      end
    end
    cpu(1'b0, 8'h10, 32'h0, r);
    n_cmp++;
    if (r !== 32'h0) begin n_err++; $display("FAIL fetch_rdcnt got %h required 00000000", r); end
  endtask

  task automatic test_underflow();
    logic [31:0] r;
    cpu(1'b0, 8'h00, 32'h0, r);
    n_cmp++;
    if (r !== 32'h0) begin n_err++; $display("FAIL underflow_rdata got %h required 00000000", r); end
    cpu(1'b0, 8'h14, 32'h0, r);
    n_cmp++;
    if (r !== 32'h1) begin n_err++; $display("FAIL underflow_runf got %h required 00000001", r); end
    cpu(1'b0, 8'h14, 32'h0, r);
    n_cmp++;
    if (r !== 32'h0) begin n_err++; $display("FAIL underflow_clear got %h required 00000000", r); end
  endtask

  task automatic test_overflow();
    logic [31:0] r;
    int          n;
    force dut.wf_pop = 1'b0;
    for (int i = 0; i < 9; i++) wr(8'h04, 32'hB000_0000 + i);
    cpu(1'b0, 8'h14, 32'h0, r);
    n_cmp++;
    if ((r & ~32'h4) !== 32'h402) begin
      n_err++; $display("FAIL overflow_status got %h required 00000402 (busy ignored)", r);
    end
    release dut.wf_pop;
    idle(14);
    n = wr_log.size();
    n_cmp++;
    if (n < 8) begin
      n_err++; $display("FAIL overflow_drain_count got %0d required >= 8", n);
    end else begin
      for (int i = 0; i < 8; i++) begin
        n_cmp++;
        if (wr_log[n-8+i] !== 32'hB000_0000 + i) begin
          n_err++; $display("FAIL overflow_drain[%0d] got %h required %h", i, wr_log[n-8+i], 32'hB000_0000 + i);
        end
      end
    end
    cpu(1'b0, 8'h14, 32'h0, r);
    n_cmp++;
    if (r !== 32'h0) begin n_err++; $display("FAIL overflow_cleared got %h required 00000000", r); end
  endtask

  task automatic test_start();
    start_cnt = 0;
    wr(8'h0C, 32'h1);
    idle(4);
    n_cmp++;
    if (start_cnt != 1) begin n_err++; $display("FAIL start_pulse got %0d cycles required 1", start_cnt); end
    wr(8'h0C, 32'h0);
    idle(4);
    n_cmp++;
    if (start_cnt != 1) begin n_err++; $display("FAIL start_zero got %0d cycles required 1", start_cnt); end
  endtask

  task automatic test_irq();
    logic [31:0] r;
`ifdef NATIVE_AIP_BUF_IRQ_EN
    wr(8'h18, 32'h2);
    i_aip_int = 1'b1;
    idle(3);
    n_cmp++;
    if (o_core_int !== 1'b1) begin n_err++; $display("FAIL irq_assert got %b required 1", o_core_int); end
    cpu(1'b0, 8'h18, 32'h0, r);
    n_cmp++;
    if (r !== 32'h3) begin n_err++; $display("FAIL irq_reg got %h required 00000003", r); end
    n_cmp++;
    if (o_core_int !== 1'b1) begin n_err++; $display("FAIL irq_held got %b required 1", o_core_int); end
    wr(8'h18, 32'h3);
    idle(2);
    n_cmp++;
    if (o_core_int !== 1'b0) begin n_err++; $display("FAIL irq_w1c got %b required 0", o_core_int); end
    i_aip_int = 1'b0;
`else
    i_aip_int = 1'b1;
    #1;
    n_cmp++;
    if (o_core_int !== 1'b1) begin n_err++; $display("FAIL irq_pass_hi got %b required 1", o_core_int); end
    i_aip_int = 1'b0;
    #1;
    n_cmp++;
    if (o_core_int !== 1'b0) begin n_err++; $display("FAIL irq_pass_lo got %b required 0", o_core_int); end
    @(negedge i_clk);
    cpu(1'b0, 8'h18, 32'h0, r);
    n_cmp++;
    if (r !== 32'h0) begin n_err++; $display("FAIL irq_reg_absent got %h required 00000000", r); end
`endif
  endtask

  task automatic test_reset_mid_fetch();
    logic [31:0] r;
    bit          seen;
    for (int i = 0; i < 8; i++) aip_src[i] = 32'h60 + i;
    src_idx = 0;
    seen = 1'b0;
    wr(8'h10, 32'd3);
    for (int i = 0; i < 10 && !seen; i++) begin
      if (o_aip_read) seen = 1'b1;
      else @(negedge i_clk);
    end
    n_cmp++;
    if (!seen) begin n_err++; $display("FAIL midreset_no_read got 0 required read strobe"); end
    @(negedge i_clk);
    i_rst = 1'b1;
    @(negedge i_clk);
    n_cmp++;
    if ({o_cpu_mem_ready, o_aip_read, o_aip_write, o_aip_start} !== 4'b0 ||
        o_cpu_mem_rdata !== 32'h0 || o_aip_dataIn !== 32'h0 || o_aip_config !== 5'h0) begin
      n_err++;
      $display("FAIL midreset_outputs got ready=%b read=%b write=%b start=%b rdata=%h dataIn=%h config=%h required all 0",
               o_cpu_mem_ready, o_aip_read, o_aip_write, o_aip_start, o_cpu_mem_rdata, o_aip_dataIn, o_aip_config);
    end
    i_rst = 1'b0;
    idle(3);
    cpu(1'b0, 8'h10, 32'h0, r);
    n_cmp++;
    if (r !== 32'h0) begin n_err++; $display("FAIL midreset_rdcnt got %h required 00000000", r); end
    cpu(1'b0, 8'h14, 32'h0, r);
    n_cmp++;
    if (r !== 32'h0) begin n_err++; $display("FAIL midreset_status got %h required 00000000", r); end
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    src_idx = 0; rd_pulses = 0; start_cnt = 0;
    for (int i = 0; i < 8; i++) aip_src[i] = '0;
    i_rst = 1'b1;
    i_cpu_mem_valid = 1'b0; i_cpu_mem_addr = '0; i_cpu_mem_wdata = '0; i_cpu_mem_wen = 1'b0;
    i_aip_sel = 1'b1; i_aip_enable = 1'b1; i_aip_int = 1'b0;
    repeat (3) @(negedge i_clk);
    i_rst = 1'b0;
    @(negedge i_clk);
    test_reset();
    test_config();
    test_push();
    test_fetch();
    test_underflow();
    test_overflow();
    test_start();
    test_irq();
    test_reset_mid_fetch();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
